// File: rtl/prbs_pkg.sv
// ----------------------------------------------------------------------------
// prbs_pkg
// Shared definitions for the 32-bit PRBS link: register width, feedback tap
// mask and the receive checker state encoding.
// ----------------------------------------------------------------------------
package prbs_pkg;

    // Width of the PRBS shift register.
    localparam int PRBS_W = 32;

    // Feedback taps 31, 6, 5 and 1. The new bit is the XOR of these
    // positions and is shifted in at bit 0.
    localparam logic [PRBS_W-1:0] PRBS32_TAPS = 32'h8000_0062;

    // Checker synchronisation states.
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping. A synchronous
// clear takes priority over an increment in the same cycle.
//
// Ports:
//   clk    in   system clock
//   rst    in   asynchronous reset, active-high
//   i_inc  in   add one this cycle (ignored once saturated)
//   i_clr  in   synchronous clear to zero, wins over i_inc
//   o_cnt  out  current count
// ----------------------------------------------------------------------------
module sat_counter #(
    parameter int P_W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_inc,
    input  logic           i_clr,
    output logic [P_W-1:0] o_cnt
);

    logic [P_W-1:0] r_cnt;

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + P_W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/prbs32_checker.sv
// ----------------------------------------------------------------------------
// prbs32_checker
// Receive-side checker for the 32-bit maximal-length PRBS stream. It fills
// its reference register from the line (HUNT), confirms P_VERIFY consecutive
// correct predictions (VERIFY), then free-runs its own generator (LOCKED)
// and counts errored and checked bits for BER measurement. Too many errors
// inside one P_WIN-bit window drops the checker back to HUNT.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   din        in   received PRBS bit
//   din_valid  in   din is sampled only when high; all state holds when low
//   clr_cnt    in   synchronous clear of err_cnt and bit_cnt
//   locked     out  checker is in LOCKED
//   err_pulse  out  one-cycle registered pulse per detected error
//   err_cnt    out  saturating count of errored bits while LOCKED
//   bit_cnt    out  saturating count of checked bits while LOCKED
//   rx_sr      out  current reference register (debug)
// ----------------------------------------------------------------------------
module prbs32_checker
    import prbs_pkg::*;
#(
    parameter int P_VERIFY   = 64,
    parameter int P_WIN      = 1024,
    parameter int P_LOSS_THR = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    input  logic        din_valid,
    input  logic        clr_cnt,
    output logic        locked,
    output logic        err_pulse,
    output logic [31:0] err_cnt,
    output logic [31:0] bit_cnt,
    output logic [31:0] rx_sr
);

    localparam int C_FILL_W = $clog2(PRBS_W);
    localparam int C_VCNT_W = (P_VERIFY > 1) ? $clog2(P_VERIFY) : 1;
    localparam int C_WIN_W  = $clog2(P_WIN);
    localparam int C_WERR_W = $clog2(P_LOSS_THR + 1);

    localparam logic [C_FILL_W-1:0] C_FILL_LAST = C_FILL_W'(PRBS_W - 1);
    localparam logic [C_VCNT_W-1:0] C_VCNT_LAST = C_VCNT_W'(P_VERIFY - 1);
    localparam logic [C_WIN_W-1:0]  C_WIN_LAST  = C_WIN_W'(P_WIN - 1);
    localparam logic [C_WERR_W:0]   C_LOSS_THR  = (C_WERR_W + 1)'(P_LOSS_THR);

    state_t                r_state;
    logic [PRBS_W-1:0]     r_rx_sr;
    logic [C_FILL_W-1:0]   r_fill_cnt;
    logic [C_VCNT_W-1:0]   r_vcnt;
    logic [C_WIN_W-1:0]    r_win_cnt;
    logic [C_WERR_W-1:0]   r_win_err;
    logic                  r_locked;
    logic                  r_err_pulse;

    logic                  w_pred;
    logic                  w_mism;
    logic [C_WERR_W:0]     w_werr_next;
    logic                  w_loss;
    logic                  w_chk;
    logic                  w_err_inc;

    // Next expected line bit from the local generator taps.
    assign w_pred = ^(r_rx_sr & PRBS32_TAPS);
    assign w_mism = din ^ w_pred;

    // One bit wider than win_err so the threshold compare cannot wrap.
    // win_err itself never exceeds P_LOSS_THR-1 because reaching the
    // threshold leaves LOCKED and clears it, which is its saturation point.
    assign w_werr_next = {1'b0, r_win_err} + (C_WERR_W + 1)'(w_mism);
    assign w_loss      = (w_werr_next >= C_LOSS_THR);

    assign w_chk     = din_valid && (r_state == LOCKED);
    assign w_err_inc = w_chk && w_mism;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= HUNT;
            r_rx_sr     <= '0;
            r_fill_cnt  <= '0;
            r_vcnt      <= '0;
            r_win_cnt   <= '0;
            r_win_err   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
        end else begin
            // Pulse only on the cycle after an errored valid bit.
            r_err_pulse <= w_err_inc;

            if (din_valid) begin
                case (r_state)
                    HUNT: begin
                        r_rx_sr <= {r_rx_sr[PRBS_W-2:0], din};
                        if (r_fill_cnt == C_FILL_LAST) begin
                            r_fill_cnt <= '0;
                            r_vcnt     <= '0;
                            r_state    <= VERIFY;
                        end else begin
                            r_fill_cnt <= r_fill_cnt + C_FILL_W'(1);
                        end
                    end

                    VERIFY: begin
                        // Still slaved to the line so a bad fill self-corrects.
                        r_rx_sr <= {r_rx_sr[PRBS_W-2:0], din};
                        // An all-zero register predicts zeros forever and
                        // would otherwise lock onto a dead line.
                        if (w_mism || (r_rx_sr == '0)) begin
                            r_vcnt <= '0;
                        end else if (r_vcnt == C_VCNT_LAST) begin
                            r_vcnt    <= '0;
                            r_win_cnt <= '0;
                            r_win_err <= '0;
                            r_locked  <= 1'b1;
                            r_state   <= LOCKED;
                        end else begin
                            r_vcnt <= r_vcnt + C_VCNT_W'(1);
                        end
                    end

                    LOCKED: begin
                        // Flywheel on the prediction: a line error is not fed
                        // back, so it is counted once instead of once per tap.
                        r_rx_sr <= {r_rx_sr[PRBS_W-2:0], w_pred};
                        if (w_loss) begin
                            r_locked   <= 1'b0;
                            r_fill_cnt <= '0;
                            r_win_cnt  <= '0;
                            r_win_err  <= '0;
                            r_state    <= HUNT;
                        end else if (r_win_cnt == C_WIN_LAST) begin
                            // The closing bit's error opens the next window.
                            r_win_cnt <= '0;
                            r_win_err <= C_WERR_W'(w_mism);
                        end else begin
                            r_win_cnt <= r_win_cnt + C_WIN_W'(1);
                            r_win_err <= w_werr_next[C_WERR_W-1:0];
                        end
                    end

                    default: begin
                        r_state <= HUNT;
                    end
                endcase
            end
        end
    end

    sat_counter #(.P_W(32)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_err_inc),
        .i_clr (clr_cnt),
        .o_cnt (err_cnt)
    );

    sat_counter #(.P_W(32)) u_bit_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_chk),
        .i_clr (clr_cnt),
        .o_cnt (bit_cnt)
    );

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign rx_sr     = r_rx_sr;

endmodule

// File: tb/tb_prbs32_checker.sv
// ----------------------------------------------------------------------------
// tb_prbs32_checker
// Self-checking bench for prbs32_checker. The reference model works on the
// transmitted bit sequence itself: the clean stream is produced from the
// bit recurrence b[n] = b[n-32]^b[n-7]^b[n-6]^b[n-2], lock is expected after
// 32+P_VERIFY clean valid bits, and the reference register is expected to
// equal the last 32 clean bits received.
// ----------------------------------------------------------------------------
module tb_prbs32_checker;

    localparam int P_VERIFY   = 64;
    localparam int P_WIN      = 1024;
    localparam int P_LOSS_THR = 16;
    localparam int LOCK_BITS  = 32 + P_VERIFY;

    logic        clk;
    logic        rst;
    logic        din;
    logic        din_valid;
    logic        clr_cnt;
    logic        locked;
    logic        err_pulse;
    logic [31:0] err_cnt;
    logic [31:0] bit_cnt;
    logic [31:0] rx_sr;

    prbs32_checker #(
        .P_VERIFY   (P_VERIFY),
        .P_WIN      (P_WIN),
        .P_LOSS_THR (P_LOSS_THR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_cnt   (err_cnt),
        .bit_cnt   (bit_cnt),
        .rx_sr     (rx_sr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- clean PRBS source ----------------
    logic prbs_q[$];
    int   prbs_pos = 0;

    task automatic next_prbs(output logic b);
        int n;
        while (prbs_q.size() <= prbs_pos) begin
            n = prbs_q.size();
            if (n < 32) prbs_q.push_back(1'b1);   // seed 32'hFFFFFFFF
            else prbs_q.push_back(prbs_q[n-32] ^ prbs_q[n-7] ^ prbs_q[n-6] ^ prbs_q[n-2]);
        end
        b = prbs_q[prbs_pos];
        prbs_pos++;
    endtask

    // ---------------- reference model ----------------
    logic        m_locked;
    int          m_hunt;      // clean valid bits since HUNT started
    logic [31:0] m_err;
    logic [31:0] m_bits;
    int          m_wpos;
    int          m_werr;
    logic        hist[$];     // last 32 clean valid bits

    function automatic logic [31:0] hist_word();
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < hist.size(); k++) r[k] = hist[hist.size()-1-k];
        return r;
    endfunction

    task automatic model_reset();
        m_locked = 1'b0;
        m_hunt   = 0;
        m_err    = '0;
        m_bits   = '0;
        m_wpos   = 0;
        m_werr   = 0;
        hist.delete();
    endtask

    // One clock: drive, advance, update model, compare all outputs.
    // inj flips the clean bit; callers only inject while the model is locked.
    task automatic step(input logic v, input logic inj, input logic clr);
        logic b;
        logic exp_pulse;
        if (v) begin
            next_prbs(b);
            din = b ^ inj;
        end else begin
            b   = 1'b0;
            din = 1'($urandom_range(0, 1));
        end
        din_valid = v;
        clr_cnt   = clr;
        @(posedge clk);
        #1;
        exp_pulse = 1'b0;
        if (v) begin
            hist.push_back(b);
            if (hist.size() > 32) void'(hist.pop_front());
            if (m_locked) begin
                if (m_bits != '1) m_bits++;
                if (inj) begin
                    exp_pulse = 1'b1;
                    if (m_err != '1) m_err++;
                end
                if (m_werr + int'(inj) >= P_LOSS_THR) begin
                    m_locked = 1'b0;
                    m_hunt   = 0;
                    m_wpos   = 0;
                    m_werr   = 0;
                end else if (m_wpos == P_WIN - 1) begin
                    m_wpos = 0;
                    m_werr = int'(inj);
                end else begin
                    m_wpos++;
                    m_werr += int'(inj);
                end
            end else begin
                m_hunt++;
                if (m_hunt == LOCK_BITS) begin
                    m_locked = 1'b1;
                    m_wpos   = 0;
                    m_werr   = 0;
                end
            end
        end
        if (clr) begin
            m_err  = '0;
            m_bits = '0;
        end
        check("locked",    {31'b0, locked},    {31'b0, m_locked});
        check("err_pulse", {31'b0, err_pulse}, {31'b0, exp_pulse});
        check("err_cnt",   err_cnt,            m_err);
        check("bit_cnt",   bit_cnt,            m_bits);
        check("rx_sr",     rx_sr,              hist_word());
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        din       = 1'b0;
        din_valid = 1'b0;
        clr_cnt   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed HUNT-fill vectors ----------------
    typedef struct {
        logic        v;
        logic        d;
        logic        clr;
        logic [31:0] exp_rx;
        logic        exp_lock;
        logic        exp_pulse;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic seen_lock;
        logic seen_pulse;
        int   n_inj;
        logic v;
        logic inj;
        logic clr;

        vecs[0] = '{v:1'b1, d:1'b1, clr:1'b0, exp_rx:32'h0000_0001, exp_lock:1'b0, exp_pulse:1'b0};
        vecs[1] = '{v:1'b1, d:1'b0, clr:1'b0, exp_rx:32'h0000_0002, exp_lock:1'b0, exp_pulse:1'b0};
        vecs[2] = '{v:1'b0, d:1'b1, clr:1'b0, exp_rx:32'h0000_0002, exp_lock:1'b0, exp_pulse:1'b0};
        vecs[3] = '{v:1'b1, d:1'b1, clr:1'b0, exp_rx:32'h0000_0005, exp_lock:1'b0, exp_pulse:1'b0};
        vecs[4] = '{v:1'b1, d:1'b1, clr:1'b1, exp_rx:32'h0000_000B, exp_lock:1'b0, exp_pulse:1'b0};
        vecs[5] = '{v:1'b0, d:1'b0, clr:1'b0, exp_rx:32'h0000_000B, exp_lock:1'b0, exp_pulse:1'b0};
        vecs[6] = '{v:1'b1, d:1'b0, clr:1'b0, exp_rx:32'h0000_0016, exp_lock:1'b0, exp_pulse:1'b0};
        vecs[7] = '{v:1'b1, d:1'b1, clr:1'b0, exp_rx:32'h0000_002D, exp_lock:1'b0, exp_pulse:1'b0};

        // Reset state
        rst = 1'b1; din = 1'b0; din_valid = 1'b0; clr_cnt = 1'b0;
        #12;
        check("rst_locked",    {31'b0, locked},    32'd0);
        check("rst_err_pulse", {31'b0, err_pulse}, 32'd0);
        check("rst_err_cnt",   err_cnt,            32'd0);
        check("rst_bit_cnt",   bit_cnt,            32'd0);
        check("rst_rx_sr",     rx_sr,              32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table: HUNT shifting, invalid cycles hold, clr in HUNT harmless
        for (int i = 0; i < 8; i++) begin
            din = vecs[i].d; din_valid = vecs[i].v; clr_cnt = vecs[i].clr;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_rx_sr", i),     rx_sr,              vecs[i].exp_rx);
            check($sformatf("vec%0d_locked", i),    {31'b0, locked},    {31'b0, vecs[i].exp_lock});
            check($sformatf("vec%0d_err_pulse", i), {31'b0, err_pulse}, {31'b0, vecs[i].exp_pulse});
            check($sformatf("vec%0d_bit_cnt", i),   bit_cnt,            32'd0);
        end

        // 1: lock from seed stream after exactly 32+P_VERIFY valid bits
        do_reset();
        for (int i = 1; i <= LOCK_BITS; i++) begin
            step(1'b1, 1'b0, 1'b0);
            if (i == LOCK_BITS - 1) check("t1_not_yet_locked", {31'b0, locked}, 32'd0);
        end
        check("t1_locked", {31'b0, locked}, 32'd1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b0);
        check("t1_bit_cnt_20", bit_cnt, 32'd20);

        // 2: single inverted bit counts exactly once
        step(1'b1, 1'b1, 1'b0);
        check("t2_pulse", {31'b0, err_pulse}, 32'd1);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 1'b0);
        check("t2_err_cnt_1", err_cnt, 32'd1);
        check("t2_still_locked", {31'b0, locked}, 32'd1);

        // 3: 16 errors inside one window drop lock, clean stream relocks
        do_reset();
        for (int i = 0; i < LOCK_BITS; i++) step(1'b1, 1'b0, 1'b0);
        for (int e = 1; e <= P_LOSS_THR; e++) begin
            for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            if (e == P_LOSS_THR - 1) check("t3_locked_at_15", {31'b0, locked}, 32'd1);
        end
        check("t3_lost_lock", {31'b0, locked}, 32'd0);
        for (int i = 0; i < LOCK_BITS; i++) step(1'b1, 1'b0, 1'b0);
        check("t3_relocked", {31'b0, locked}, 32'd1);
        check("t3_err_cnt_16", err_cnt, 32'd16);

        // 4: constant streams never lock
        do_reset();
        seen_lock = 1'b0; seen_pulse = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            din = (i >= 10000); din_valid = 1'b1;
            @(posedge clk);
            #1;
            seen_lock  |= locked;
            seen_pulse |= err_pulse;
        end
        din_valid = 1'b0;
        check("t4_never_locked", {31'b0, seen_lock},  32'd0);
        check("t4_no_pulse",     {31'b0, seen_pulse}, 32'd0);
        check("t4_err_cnt",      err_cnt,             32'd0);
        check("t4_bit_cnt",      bit_cnt,             32'd0);

        // 5: valid every other cycle locks after 96 valid bits (192 clocks)
        do_reset();
        for (int i = 0; i < 2 * LOCK_BITS; i++) begin
            step(((i % 2) == 0), 1'b0, 1'b0);
            if (i == 2 * LOCK_BITS - 3) check("t5_not_yet_locked", {31'b0, locked}, 32'd0);
            if (i == 2 * LOCK_BITS - 2) check("t5_locked", {31'b0, locked}, 32'd1);
        end

        // 6: clr_cnt beats a same-cycle error; async reset mid-lock
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        check("t6_clr_wins", err_cnt, 32'd0);
        step(1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("t6_rst_locked",  {31'b0, locked}, 32'd0);
        check("t6_rst_err_cnt", err_cnt,         32'd0);
        check("t6_rst_bit_cnt", bit_cnt,         32'd0);
        check("t6_rst_rx_sr",   rx_sr,           32'd0);
        do_reset();

        // Randomised: sparse valid, sparse errors, occasional clear
        for (int i = 0; i < LOCK_BITS; i++) step(1'b1, 1'b0, 1'b0);
        n_inj = 0;
        for (int i = 0; i < 1500; i++) begin
            v   = ($urandom_range(0, 3) != 0);
            inj = v && m_locked && (n_inj < 10) && ($urandom_range(0, 49) == 0);
            clr = ($urandom_range(0, 199) == 0);
            if (inj) n_inj++;
            step(v, inj, clr);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
